// File: rtl/rpn_stack_sequencer.sv
// RPN command sequencer for the 16-bit stack memory. It turns operand/operator tokens into
// one-hot push/pop commands and tracks occupancy so that illegal commands never reach the stack.
module rpn_stack_sequencer #(
  parameter  int W     = 16,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic          tok_is_op,
  input  logic [W-1:0]  tok_data,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [W-1:0]  stk_wdata,
  input  logic [W-1:0]  stk_rdata,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  output logic [CW-1:0] count,
  output logic          err_ovf,
  output logic          err_unf,
  input  logic          err_clr
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PUSH_OPND = 3'd1;
  localparam logic [2:0] POP_B     = 3'd2;
  localparam logic [2:0] POP_A     = 3'd3;
  localparam logic [2:0] CAP_A     = 3'd4;
  localparam logic [2:0] PUSH_RES  = 3'd5;

  logic [2:0]   state;
  logic [1:0]   opc;
  logic [W-1:0] b_q;
  logic [W-1:0] alu_r;
  logic         accept;

  assign accept = tok_valid & tok_ready;

  // In CAP_A the stack's read port carries A, the deeper of the two operands
  always_comb begin
    alu_r = '0;
    case (opc)
      2'd0:    alu_r = stk_rdata + b_q;
      2'd1:    alu_r = stk_rdata - b_q;
      2'd2:    alu_r = stk_rdata & b_q;
      default: alu_r = stk_rdata ^ b_q;
    endcase
  end

  // Outputs are registered, so each command is loaded on the edge that enters its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tok_ready <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_wdata <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      count     <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      opc       <= '0;
      b_q       <= '0;
    end else begin
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      res_valid <= 1'b0;
      if (err_clr) begin
        err_ovf <= 1'b0;
        err_unf <= 1'b0;
      end
      case (state)
        IDLE: begin
          tok_ready <= 1'b1;
          if (accept) begin
            if (!tok_is_op) begin
              if (count < CW'(DEPTH)) begin
                stk_wdata <= tok_data;
                stk_push  <= 1'b1;
                tok_ready <= 1'b0;
                state     <= PUSH_OPND;
              end else begin
                err_ovf <= 1'b1;
              end
            end else begin
              if (count >= CW'(2)) begin
                opc       <= tok_data[1:0];
                stk_pop   <= 1'b1;
                tok_ready <= 1'b0;
                state     <= POP_B;
              end else begin
                err_unf <= 1'b1;
              end
            end
          end
        end
        PUSH_OPND: begin
          count     <= count + 1'b1;
          tok_ready <= 1'b1;
          state     <= IDLE;
        end
        POP_B: begin
          count   <= count - 1'b1;
          stk_pop <= 1'b1;
          state   <= POP_A;
        end
        POP_A: begin
          count <= count - 1'b1;
          b_q   <= stk_rdata;
          state <= CAP_A;
        end
        CAP_A: begin
          stk_push  <= 1'b1;
          stk_wdata <= alu_r;
          res_valid <= 1'b1;
          res_data  <= alu_r;
          state     <= PUSH_RES;
        end
        PUSH_RES: begin
          count     <= count + 1'b1;
          tok_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          tok_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Bench for rpn_stack_sequencer: a directed token table, hand-written reset and held-valid
// sequences, then random tokens scored against a queue-based RPN model with a stack memory model.
module tb_rpn_stack_sequencer;
  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tok_valid = 1'b0, tok_is_op = 1'b0, err_clr = 1'b0;
  logic [W-1:0] tok_data = '0;
  logic         tok_ready, stk_push, stk_pop, res_valid, err_ovf, err_unf;
  logic [W-1:0] stk_wdata, stk_rdata, res_data;
  logic [3:0]   count;

  always #5 clk = ~clk;

  rpn_stack_sequencer #(.W(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .res_valid(res_valid), .res_data(res_data),
    .count(count), .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr)
  );

  // Stack memory: read data appears the cycle after a pop, and it shares the reset
  logic [W-1:0] mem [0:D-1];
  int           sp;
  logic [W-1:0] rdata;
  assign stk_rdata = rdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= 0;
      rdata <= '0;
    end else begin
      if (stk_push && sp < D) begin mem[sp] <= stk_wdata; sp <= sp + 1; end
      if (stk_pop && sp > 0) begin rdata <= mem[sp-1]; sp <= sp - 1; end
    end
  end

  int overlap = 0, resbad = 0, stkbad = 0, acc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stk_push && stk_pop) overlap++;
      if (res_valid && !(stk_push && stk_wdata == res_data)) resbad++;
      if ((stk_push && sp >= D) || (stk_pop && sp == 0) || int'(count) != sp) stkbad++;
      if (tok_valid && tok_ready) acc++;
    end
  end

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input bit op, input logic [W-1:0] d, input bit clr,
                      output int lat, output int nres, output logic [W-1:0] rv);
    int w;
    lat = 99; nres = 0; rv = '0;
    @(posedge clk); #1;
    tok_valid = 1'b1; tok_is_op = op; tok_data = d; err_clr = clr;
    w = 0;
    do begin @(negedge clk); w++; end while (!tok_ready && w < 20);
    if (!tok_ready) begin tok_valid = 1'b0; err_clr = 1'b0; return; end
    @(posedge clk); #1;
    tok_valid = 1'b0; err_clr = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (res_valid) begin nres++; rv = res_data; end
      if (tok_ready) begin lat = n; break; end
    end
  endtask

  typedef struct {
    bit op; logic [W-1:0] d; bit clr;
    int lat; int nres; logic [W-1:0] rv; int cnt; bit ovf; bit unf;
  } vec_t;

  function automatic logic [W-1:0] rpn(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         tv[$];
    int           lat, nres, a0, exp_lat, exp_nres;
    logic [W-1:0] rv, a, b, r;
    logic [W-1:0] q[$];
    bit           ovf_m, unf_m, op, clr;
    logic [W-1:0] d;

    tv.push_back('{0, 16'h0005, 0, 2, 0, 16'h0000, 1, 0, 0});
    tv.push_back('{0, 16'h0003, 0, 2, 0, 16'h0000, 2, 0, 0});
    tv.push_back('{1, 16'hABC5, 0, 5, 1, 16'h0002, 1, 0, 0});
    tv.push_back('{0, 16'hFFFF, 0, 2, 0, 16'h0000, 2, 0, 0});
    tv.push_back('{0, 16'h0001, 0, 2, 0, 16'h0000, 3, 0, 0});
    tv.push_back('{1, 16'h0000, 0, 5, 1, 16'h0000, 2, 0, 0});
    tv.push_back('{0, 16'hF0F0, 0, 2, 0, 16'h0000, 3, 0, 0});
    tv.push_back('{0, 16'hFF00, 0, 2, 0, 16'h0000, 4, 0, 0});
    tv.push_back('{1, 16'h0003, 0, 5, 1, 16'h0FF0, 3, 0, 0});
    tv.push_back('{1, 16'h0002, 0, 5, 1, 16'h0000, 2, 0, 0});
    tv.push_back('{1, 16'h0002, 0, 5, 1, 16'h0000, 1, 0, 0});
    tv.push_back('{1, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 1});
    tv.push_back('{0, 16'h1111, 1, 2, 0, 16'h0000, 2, 0, 0});
    for (int i = 1; i <= 6; i++)
      tv.push_back('{0, W'(i * 16), 0, 2, 0, 16'h0000, 2 + i, 0, 0});
    tv.push_back('{0, 16'h1234, 1, 1, 0, 16'h0000, 8, 1, 0});
    tv.push_back('{1, 16'h0001, 0, 5, 1, 16'hFFF0, 7, 1, 0});

    #12;
    chk("reset_outputs", int'({tok_ready, stk_push, stk_pop, res_valid, err_ovf, err_unf}), 0);
    chk("reset_data", int'({stk_wdata, res_data}), 0);
    chk("reset_count", int'(count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("ready_after_reset", int'(tok_ready), 1);

    foreach (tv[i]) begin
      send(tv[i].op, tv[i].d, tv[i].clr, lat, nres, rv);
      chk($sformatf("tv%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("tv%0d_nres", i), nres, tv[i].nres);
      if (tv[i].nres != 0) chk($sformatf("tv%0d_res", i), int'(rv), int'(tv[i].rv));
      chk($sformatf("tv%0d_count", i), int'(count), tv[i].cnt);
      chk($sformatf("tv%0d_ovf", i), int'(err_ovf), int'(tv[i].ovf));
      chk($sformatf("tv%0d_unf", i), int'(err_unf), int'(tv[i].unf));
    end

    // Reset while the sequencer sits in POP_A
    @(posedge clk); #1;
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 16'h0000;
    do @(negedge clk); while (!tok_ready);
    @(posedge clk); #1 tok_valid = 1'b0;
    @(posedge clk); #1;
    chk("pop_a_reached", int'(stk_pop), 1);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", int'({tok_ready, stk_push, stk_pop, res_valid, err_ovf, err_unf}), 0);
    chk("midop_reset_data", int'({stk_wdata, res_data}), 0);
    chk("midop_reset_count", int'(count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(0, 16'h00AA, 0, lat, nres, rv);
    chk("post_reset_latency", lat, 2);
    chk("post_reset_count", int'(count), 1);
    send(0, 16'h0007, 0, lat, nres, rv);

    // Operator held valid for its whole execution with changing data
    a0 = acc;
    @(posedge clk); #1;
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 16'h0000;
    do @(negedge clk); while (!tok_ready);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      #1 tok_data = W'($urandom); tok_is_op = 1'($urandom);
      @(posedge clk);
    end
    #1 tok_valid = 1'b0;
    @(negedge clk);
    chk("held_single_accept", acc - a0, 1);
    chk("held_count", int'(count), 1);
    chk("held_result", int'(mem[0]), 16'h00B1);

    q = {16'h00B1};
    ovf_m = 0; unf_m = 0;
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 9) < 4);
      d = W'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      if (clr) begin ovf_m = 0; unf_m = 0; end
      exp_lat = 1; exp_nres = 0; r = '0;
      if (!op) begin
        if (q.size() < D) begin q.push_back(d); exp_lat = 2; end
        else ovf_m = 1;
      end else begin
        if (q.size() >= 2) begin
          b = q.pop_back(); a = q.pop_back();
          r = rpn(d[1:0], a, b);
          q.push_back(r);
          exp_lat = 5; exp_nres = 1;
        end else unf_m = 1;
      end
      send(op, d, clr, lat, nres, rv);
      chk($sformatf("rnd%0d_latency", i), lat, exp_lat);
      chk($sformatf("rnd%0d_nres", i), nres, exp_nres);
      if (exp_nres != 0) chk($sformatf("rnd%0d_res", i), int'(rv), int'(r));
      chk($sformatf("rnd%0d_count", i), int'(count), q.size());
      chk($sformatf("rnd%0d_ovf", i), int'(err_ovf), int'(ovf_m));
      chk($sformatf("rnd%0d_unf", i), int'(err_unf), int'(unf_m));
    end
    chk("final_depth", sp, q.size());
    foreach (q[i]) chk($sformatf("final_mem%0d", i), int'(mem[i]), int'(q[i]));

    chk("push_pop_overlap", overlap, 0);
    chk("res_vs_push", resbad, 0);
    chk("stack_cmd_legal", stkbad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
